joint_frame_packer: RTL

//  Downstream consumer of the joint block's 38-bit array_out0. Buffers each strobed 38-bit
//  hit array in a small FIFO and serialises it as a fixed 5-word, 16-bit frame:

---
 rtl/joint_frame_packer_if.sv | 22 ++
 rtl/joint_frame_packer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/joint_frame_packer_if.sv
// Link bundle between the joint block and the frame packer: array strobe in, framed word stream out.
// The slave view is the packer itself; the master view is whatever drives and consumes it.
interface joint_frame_packer_if;
    logic [37:0] array_in;
    logic        array_valid;
    logic        word_ready;
    logic [15:0] word_out;
    logic        word_valid;
    logic [3:0]  frame_seq;
    logic        overflow;
    logic [7:0]  drop_count;

    modport slave (
        input  array_in, array_valid, word_ready,
        output word_out, word_valid, frame_seq, overflow, drop_count
    );

    modport master (
        output array_in, array_valid, word_ready,
        input  word_out, word_valid, frame_seq, overflow, drop_count
    );
endinterface

// File: rtl/joint_frame_packer.sv
// Buffers strobed 38-bit hit arrays with their popcount and serialises each one as a
// 5-word frame (header, 3 data words, trailer) over a valid/ready link.
module joint_frame_packer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] HEADER     = 16'hAAAA,
    parameter logic [15:0] TRAILER    = 16'h5555
) (
    input logic                  clk,
    input logic                  rst,
    joint_frame_packer_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, HDR, D1, D2, D3, TRL} state_t;

    state_t         r_state;
    state_t         w_nextState;

    // Entry layout: {array[37:0], popcount[5:0]}
    logic [43:0]    r_fifoMem [FIFO_DEPTH];
    logic [PTR_W:0] r_wrPtr;
    logic [PTR_W:0] r_rdPtr;

    logic [43:0]    r_frame;
    logic [43:0]    w_nextFrame;
    logic [15:0]    r_wordOut;
    logic [15:0]    w_nextWord;
    logic           r_wordValid;
    logic [3:0]     r_frameSeq;
    logic [3:0]     w_nextSeq;
    logic           r_overflow;
    logic [7:0]     r_dropCount;

    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic           w_accept;
    logic [5:0]     w_popCount;

    assign w_popCount = 6'($countones(bus.array_in));
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                        (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign w_accept   = r_wordValid && bus.word_ready;
    // A pop in the same cycle frees the slot, so a strobe into a full FIFO is only lost without one
    assign w_push     = bus.array_valid && (!w_full || w_pop);
    assign w_drop     = bus.array_valid && w_full && !w_pop;

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = HDR;
                end
            end
            HDR: if (w_accept) w_nextState = D1;
            D1:  if (w_accept) w_nextState = D2;
            D2:  if (w_accept) w_nextState = D3;
            D3:  if (w_accept) w_nextState = TRL;
            TRL: begin
                if (w_accept) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = HDR;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Word for the state being entered, so word_out can be a plain register
    always_comb begin
        w_nextFrame = w_pop ? r_fifoMem[r_rdPtr[PTR_W-1:0]] : r_frame;
        w_nextSeq   = (r_state == TRL && w_accept) ? r_frameSeq + 4'd1 : r_frameSeq;
        w_nextWord  = 16'h0000;
        case (w_nextState)
            HDR:     w_nextWord = HEADER;
            D1:      w_nextWord = w_nextFrame[43:28];
            D2:      w_nextWord = w_nextFrame[27:12];
            D3:      w_nextWord = {w_nextFrame[11:0], w_nextSeq};
            TRL:     w_nextWord = TRAILER;
            default: w_nextWord = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wordOut   <= 16'h0000;
            r_wordValid <= 1'b0;
            r_frame     <= 44'h0;
            r_frameSeq  <= 4'd0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_overflow  <= 1'b0;
            r_dropCount <= 8'd0;
        end else begin
            r_state     <= w_nextState;
            r_wordOut   <= w_nextWord;
            r_wordValid <= (w_nextState != IDLE);
            r_frame     <= w_nextFrame;
            r_frameSeq  <= w_nextSeq;
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropCount != 8'hFF) r_dropCount <= r_dropCount + 8'd1;
            end
        end
    end

    // Storage needs no reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (w_push) r_fifoMem[r_wrPtr[PTR_W-1:0]] <= {bus.array_in, w_popCount};
    end

    assign bus.word_out   = r_wordOut;
    assign bus.word_valid = r_wordValid;
    assign bus.frame_seq  = r_frameSeq;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_dropCount;

endmodule
